// File: rtl/apb_slave_mem_if.sv
// APB3 bus bundle between one requester port and one completer.
// The master modport is the requester side; the slave modport is the completer side.
interface apb_slave_mem_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_slave_mem.sv
// APB3 completer: word register memory with a read-only access counter in the top
// slot, fixed wait-state insertion and PSLVERR on bad address, misalignment or counter write.
module apb_slave_mem #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           DEPTH       = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h2000_0000,
  parameter int unsigned           WAIT_CYCLES = 1
) (
  input logic           clk,
  input logic           rst_n,
  apb_slave_mem_if.slave apb
);

  localparam int unsigned           IDX_W   = $clog2(DEPTH);
  localparam int unsigned           WAIT_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [ADDR_WIDTH-1:0] SPAN    = ADDR_WIDTH'(DEPTH * 4);
  localparam logic [IDX_W-1:0]      CNT_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e                state_q, state_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  err_q, err_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  // Decode of the current bus address; only consulted in the setup phase.
  logic [ADDR_WIDTH-1:0] offset;
  logic                  dec_hit;
  logic [IDX_W-1:0]      dec_idx;
  logic                  dec_err;

  assign offset  = apb.paddr - BASE_ADDR;
  assign dec_hit = (apb.paddr >= BASE_ADDR) && (offset < SPAN);
  assign dec_idx = offset[IDX_W+1:2];
  assign dec_err = !dec_hit || (apb.paddr[1:0] != 2'b00) || (apb.pwrite && (dec_idx == CNT_IDX));

  assign apb.pready  = (state_q == ACCESS) && (wait_q == '0);
  assign apb.pslverr = apb.pready && err_q;
  assign apb.prdata  = prdata_q;

  always_comb begin
    // NOTE: every _d starts from its _q so no path through this block can infer a latch.
    state_d  = state_q;
    wait_d   = wait_q;
    idx_d    = idx_q;
    err_d    = err_q;
    pwrite_d = pwrite_q;
    prdata_d = prdata_q;
    mem_d    = mem_q;

    unique case (state_q)
      IDLE: begin
        if (apb.psel && !apb.penable) begin
          state_d  = ACCESS;
          wait_d   = WAIT_W'(WAIT_CYCLES);
          idx_d    = dec_idx;
          err_d    = dec_err;
          pwrite_d = apb.pwrite;
          if (!apb.pwrite) prdata_d = dec_err ? '0 : mem_q[dec_idx];
        end
      end
      ACCESS: begin
        if (!apb.psel) begin
          state_d = IDLE;
        end else if (wait_q == '0) begin
          state_d = IDLE;
          if (!err_q) begin
            // Slot CNT_IDX is never a write target: that case was decoded as an error.
            if (pwrite_q) mem_d[idx_q] = apb.pwdata;
            mem_d[CNT_IDX] = mem_d[CNT_IDX] + DATA_WIDTH'(1);
          end
        end else if (apb.penable) begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wait_q   <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
      pwrite_q <= 1'b0;
      prdata_q <= '0;
      // NOTE: the memory is reset because it is read back as defined zeros after reset.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      pwrite_q <= pwrite_d;
      prdata_q <= prdata_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: three instances (1, 0 and 3 wait states) on a shared bus with
// gated selects, directed scenarios followed by random transfers against a word/counter model.
module tb_apb_slave_mem;

  localparam logic [31:0] BASE = 32'h2000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  int          cur;

  logic        pready_c, pslverr_c;
  logic [31:0] prdata_c;

  int checks = 0;
  int errors = 0;

  // Reference model: plain words, a separate counter, and the last read value per instance.
  logic [31:0] mmem  [3][15];
  logic [31:0] mcnt  [3];
  logic [31:0] mlast [3];

  apb_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
  apb_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();
  apb_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus2 ();

  assign bus0.psel = psel && (cur == 0);
  assign bus1.psel = psel && (cur == 1);
  assign bus2.psel = psel && (cur == 2);
  assign bus0.penable = penable;
  assign bus1.penable = penable;
  assign bus2.penable = penable;
  assign bus0.pwrite = pwrite;
  assign bus1.pwrite = pwrite;
  assign bus2.pwrite = pwrite;
  assign bus0.paddr = paddr;
  assign bus1.paddr = paddr;
  assign bus2.paddr = paddr;
  assign bus0.pwdata = pwdata;
  assign bus1.pwdata = pwdata;
  assign bus2.pwdata = pwdata;

  apb_slave_mem #(.BASE_ADDR(BASE), .WAIT_CYCLES(1)) dut0 (.clk(clk), .rst_n(rst_n), .apb(bus0));
  apb_slave_mem #(.BASE_ADDR(BASE), .WAIT_CYCLES(0)) dut1 (.clk(clk), .rst_n(rst_n), .apb(bus1));
  apb_slave_mem #(.BASE_ADDR(BASE), .WAIT_CYCLES(3)) dut2 (.clk(clk), .rst_n(rst_n), .apb(bus2));

  always #5 clk = ~clk;

  always_comb begin
    case (cur)
      1:       begin pready_c = bus1.pready; pslverr_c = bus1.pslverr; prdata_c = bus1.prdata; end
      2:       begin pready_c = bus2.pready; pslverr_c = bus2.pslverr; prdata_c = bus2.prdata; end
      default: begin pready_c = bus0.pready; pslverr_c = bus0.pslverr; prdata_c = bus0.prdata; end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic int wait_of(input int d);
    case (d)
      1:       return 0;
      2:       return 3;
      default: return 1;
    endcase
  endfunction

  function automatic bit model_err(input bit wr, input logic [31:0] a);
    if (a < BASE || a >= BASE + 32'd64) return 1'b1;
    if (a % 4 != 0) return 1'b1;
    if (wr && a == BASE + 32'd60) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_read(input int d, input logic [31:0] a);
    int idx;
    idx = int'((a - BASE) / 4);
    if (idx == 15) return mcnt[d];
    return mmem[d][idx];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 15; i++) mmem[d][i] = '0;
      mcnt[d]  = '0;
      mlast[d] = '0;
    end
  endtask

  // One complete transfer starting in the current cycle; leaves the bus idle afterwards,
  // so back-to-back calls put the next setup phase right after the completion edge.
  task automatic apb_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                          output logic [31:0] rd, output bit err, output int cycles);
    int n;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    @(posedge clk); #1;
    penable = 1'b1;
    paddr   = $urandom;
    pwrite  = ~wr;
    cycles  = 2;
    n       = 0;
    while (!pready_c && n < 20) begin
      check("pslverr_stall", {31'b0, pslverr_c}, 32'd0);
      @(posedge clk); #1;
      cycles++;
      n++;
    end
    check("pready_timeout", {31'b0, pready_c}, 32'd1);
    rd  = prdata_c;
    err = pslverr_c;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic do_xfer(input int d, input bit wr, input logic [31:0] addr,
                         input logic [31:0] data, output logic [31:0] rd);
    bit          err, exp_err;
    int          cycles;
    logic [31:0] exp_rd;
    cur = d;
    apb_xfer(wr, addr, data, rd, err, cycles);
    exp_err = model_err(wr, addr);
    check("pslverr", {31'b0, err}, {31'b0, exp_err});
    check("cycles", cycles, 2 + wait_of(d));
    if (!wr) begin
      exp_rd = exp_err ? 32'd0 : model_read(d, addr);
      check("prdata", rd, exp_rd);
      mlast[d] = exp_rd;
    end else begin
      check("prdata_hold", prdata_c, mlast[d]);
    end
    if (!exp_err) begin
      if (wr) mmem[d][int'((addr - BASE) / 4)] = data;
      mcnt[d] = mcnt[d] + 32'd1;
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    model_reset();
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; cur = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pready", {29'b0, bus0.pready, bus1.pready, bus2.pready}, 32'd0);
    check("rst_pslverr", {29'b0, bus0.pslverr, bus1.pslverr, bus2.pslverr}, 32'd0);
    check("rst_prdata", bus0.prdata | bus1.prdata | bus2.prdata, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Write then read back, then the counter.
    do_xfer(0, 1'b1, BASE + 32'h08, 32'hDEADBEEF, rd);
    do_xfer(0, 1'b0, BASE + 32'h08, 32'h0, rd);
    check("wr_rd_data", rd, 32'hDEADBEEF);
    do_xfer(0, 1'b0, BASE + 32'h3C, 32'h0, rd);
    check("cnt_after_wr_rd", rd, 32'd2);

    // Error responses leave memory and counter untouched.
    do_xfer(0, 1'b1, BASE + 32'h40, 32'h55555555, rd);
    do_xfer(0, 1'b0, BASE + 32'h06, 32'h0, rd);
    do_xfer(0, 1'b1, BASE + 32'h3C, 32'h1234, rd);
    do_xfer(0, 1'b0, BASE + 32'h3C, 32'h0, rd);
    check("cnt_after_errs", rd, 32'd3);
    do_xfer(0, 1'b0, BASE + 32'h08, 32'h0, rd);
    check("mem_after_errs", rd, 32'hDEADBEEF);

    // Access phase without setup is ignored.
    cur = 0; psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = BASE; pwdata = 32'hFFFF0000;
    repeat (3) begin
      @(posedge clk); #1;
      check("no_setup_pready", {31'b0, pready_c}, 32'd0);
    end
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;

    // Zero-wait back-to-back on dut1.
    for (int i = 0; i < 8; i++) do_xfer(1, 1'b1, BASE + 32'(i * 4), 32'(i * 3), rd);
    for (int i = 0; i < 8; i++) begin
      do_xfer(1, 1'b0, BASE + 32'(i * 4), 32'h0, rd);
      check("zw_readback", rd, 32'(i * 3));
    end
    do_xfer(1, 1'b0, BASE + 32'h3C, 32'h0, rd);
    check("zw_cnt", rd, 32'd16);

    // Abort a stalled write on dut2.
    do_xfer(2, 1'b1, BASE + 32'h10, 32'h11112222, rd);
    cur = 2; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = BASE + 32'h10; pwdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    penable = 1'b1;
    check("abort_acc1", {31'b0, pready_c}, 32'd0);
    @(posedge clk); #1;
    check("abort_acc2", {31'b0, pready_c}, 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    check("abort_after", {31'b0, pready_c}, 32'd0);
    do_xfer(2, 1'b0, BASE + 32'h10, 32'h0, rd);
    check("abort_old_val", rd, 32'h11112222);
    do_xfer(2, 1'b0, BASE + 32'h3C, 32'h0, rd);
    check("abort_cnt", rd, 32'd2);

    // Reset during a stalled write.
    cur = 2; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = BASE + 32'h08; pwdata = 32'hCAFE0000;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_stall", {31'b0, pready_c}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_pready", {31'b0, pready_c}, 32'd0);
    check("rst_mid_prdata2", bus2.prdata, 32'd0);
    check("rst_mid_prdata0", bus0.prdata, 32'd0);
    psel = 1'b0; penable = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    do_xfer(2, 1'b0, BASE + 32'h3C, 32'h0, rd);
    check("post_rst_cnt", rd, 32'd0);
    for (int i = 0; i < 15; i++) do_xfer(2, 1'b0, BASE + 32'(i * 4), 32'h0, rd);
    do_xfer(0, 1'b0, BASE + 32'h08, 32'h0, rd);
    check("post_rst_slot2", rd, 32'd0);

    // Random traffic across all three instances.
    for (int t = 0; t < 120; t++) begin
      int          d, slot;
      bit          wr;
      logic [31:0] addr;
      d    = int'($urandom_range(0, 2));
      wr   = 1'($urandom_range(0, 1));
      slot = int'($urandom_range(0, 17));
      addr = BASE + 32'(slot * 4);
      if ($urandom_range(0, 7) == 0) addr = addr + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 15) == 0) addr = BASE - 32'(4 * $urandom_range(1, 4));
      do_xfer(d, wr, addr, $urandom, rd);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    for (int d = 0; d < 3; d++) do_xfer(d, 1'b0, BASE + 32'h3C, 32'h0, rd);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
